// File: rtl/neuron_accumulator_bank_pkg.sv
// Shared width derivations and input-beat field offsets for the accumulator bank.
package neuron_accumulator_bank_pkg;

    // The channel field is at least one bit wide, even when there is only one channel.
    function automatic int calcCw(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

    // Each lane sums up to NA weights and may also carry a negated -2^(WD-1).
    function automatic int calcOw(input int na, input int wd);
        return $clog2(na) + wd + 1;
    endfunction

    // Field offsets for the input beat {ch, first, last, en, neg, w[NB-1]..w[0]}.
    function automatic int offNeg(input int nb, input int wd);
        return nb * wd;
    endfunction

    function automatic int offEn(input int nb, input int wd);
        return nb * wd + 1;
    endfunction

    function automatic int offLast(input int nb, input int wd);
        return nb * wd + 2;
    endfunction

    function automatic int offFirst(input int nb, input int wd);
        return nb * wd + 3;
    endfunction

    function automatic int offCh(input int nb, input int wd);
        return nb * wd + 4;
    endfunction

    function automatic int inWidth(input int nch, input int nb, input int wd);
        return calcCw(nch) + 4 + nb * wd;
    endfunction

    function automatic int outWidth(input int nch, input int nb, input int na, input int wd);
        return calcCw(nch) + nb * calcOw(na, wd);
    endfunction

endpackage

// File: rtl/neuron_accumulator_bank_if.sv
// Beat input stream and result output stream of the accumulator bank.
interface neuron_accumulator_bank_if #(
    parameter int DW = 13,
    parameter int RW = 15
);
    logic          iValid_AS;
    logic          oReady_AS;
    logic [DW-1:0] iData_AS;
    logic          oValid_BM;
    logic          iReady_BM;
    logic [RW-1:0] oData_BM;

    modport master (
        output iValid_AS, iData_AS, iReady_BM,
        input  oReady_AS, oValid_BM, oData_BM
    );

    modport slave (
        input  iValid_AS, iData_AS, iReady_BM,
        output oReady_AS, oValid_BM, oData_BM
    );
endinterface

// File: rtl/neuron_accumulator_bank_fifo.sv
// Result FIFO; ready depends only on registered occupancy, so no input-to-ready path exists.
module nab_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iValid,
    output logic             oReady,
    input  logic [WIDTH-1:0] iData,
    output logic             oValid,
    input  logic             iReady,
    output logic [WIDTH-1:0] oData
);
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wrPtr;
    logic [PW-1:0]    rdPtr;
    logic [CNTW-1:0]  count;
    logic             doPush;
    logic             doPop;

    function automatic logic [PW-1:0] ptrNext(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign oReady = (count < CNTW'(DEPTH));
    assign oValid = (count != '0);
    assign oData  = mem[rdPtr];
    assign doPush = iValid && oReady;
    assign doPop  = oValid && iReady;

    // Storage needs no reset; occupancy decides what is visible.
    always_ff @(posedge iCLK) begin
        if (doPush) mem[wrPtr] <= iData;
    end

    // Pointers and occupancy; a simultaneous push and pop leaves occupancy unchanged.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= ptrNext(wrPtr);
            if (doPop)  rdPtr <= ptrNext(rdPtr);
            case ({doPush, doPop})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/neuron_accumulator_bank.sv
// Multi-channel, multi-lane signed weight accumulator with saturating sums and a result FIFO.
module neuron_accumulator_bank
    import neuron_accumulator_bank_pkg::*;
#(
    parameter int NA    = 4,
    parameter int NB    = 4,
    parameter int WD    = 4,
    parameter int NCH   = 2,
    parameter int DEPTH = 2
) (
    input  logic                   iCLK,
    input  logic                   iRST,
    neuron_accumulator_bank_if.slave bus,
    output logic [NCH-1:0]         oErr
);
    localparam int CW       = calcCw(NCH);
    localparam int OW       = calcOw(NA, WD);
    localparam int RW       = CW + NB * OW;
    localparam int CNTW     = $clog2(NA + 2);
    localparam int POSNEG   = offNeg(NB, WD);
    localparam int POSEN    = offEn(NB, WD);
    localparam int POSLAST  = offLast(NB, WD);
    localparam int POSFIRST = offFirst(NB, WD);
    localparam int POSCH    = offCh(NB, WD);

    logic [CW-1:0]        beatCh;
    logic                 beatFirst;
    logic                 beatLast;
    logic                 beatEn;
    logic                 beatNeg;
    logic                 chOk;
    logic                 doBeat;
    logic                 push;
    logic                 fifoReady;
    logic [RW-1:0]        pushData;
    logic signed [OW-1:0] newAcc [NB];
    logic signed [OW-1:0] acc [NCH][NB];
    logic [CNTW-1:0]      cnt [NCH];

    // One lane step: optional (negated) sign-extended weight added with clamping, never wrapping.
    function automatic logic signed [OW-1:0] laneNext(
        input logic signed [OW-1:0] base,
        input logic [WD-1:0]        w,
        input logic                 en,
        input logic                 neg
    );
        logic signed [WD:0] wExt;
        logic signed [WD:0] term;
        logic        [OW:0] sum;
        wExt = {w[WD-1], w};
        term = en ? (neg ? -wExt : wExt) : '0;
        sum  = {{(OW - WD){term[WD]}}, term} + {base[OW-1], base};
        if (sum[OW] != sum[OW-1])
            return sum[OW] ? {1'b1, {(OW - 1){1'b0}}} : {1'b0, {(OW - 1){1'b1}}};
        return sum[OW-1:0];
    endfunction

    assign beatCh    = bus.iData_AS[POSCH +: CW];
    assign beatFirst = bus.iData_AS[POSFIRST];
    assign beatLast  = bus.iData_AS[POSLAST];
    assign beatEn    = bus.iData_AS[POSEN];
    assign beatNeg   = bus.iData_AS[POSNEG];
    assign chOk      = (int'(beatCh) < NCH);

    // Beats to channels that do not exist are accepted but change nothing.
    assign bus.oReady_AS = fifoReady;
    assign doBeat        = bus.iValid_AS && fifoReady && chOk;
    assign push          = doBeat && beatLast;

    // Next accumulator values for the addressed channel and the result word pushed on last.
    always_comb begin
        pushData = '0;
        pushData[NB*OW +: CW] = beatCh;
        for (int b = 0; b < NB; b++) begin
            newAcc[b] = laneNext((beatFirst || !chOk) ? '0 : acc[beatCh][b],
                                 bus.iData_AS[b*WD +: WD], beatEn, beatNeg);
            pushData[b*OW +: OW] = newAcc[b];
        end
    end

    // Per-channel accumulators and beat counters; a last beat hands the sum off and clears.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            for (int c = 0; c < NCH; c++) begin
                cnt[c] <= '0;
                for (int b = 0; b < NB; b++) acc[c][b] <= '0;
            end
        end else if (doBeat) begin
            if (beatLast) begin
                cnt[beatCh] <= '0;
                for (int b = 0; b < NB; b++) acc[beatCh][b] <= '0;
            end else begin
                for (int b = 0; b < NB; b++) acc[beatCh][b] <= newAcc[b];
                if (beatFirst)
                    cnt[beatCh] <= CNTW'(1);
                else if (cnt[beatCh] != CNTW'(NA + 1))
                    cnt[beatCh] <= cnt[beatCh] + CNTW'(1);
            end
        end
    end

    // Sticky frame-length error: a continuation beat arriving after NA beats already counted.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            oErr <= '0;
        end else if (doBeat && !beatFirst && (cnt[beatCh] >= CNTW'(NA))) begin
            oErr[beatCh] <= 1'b1;
        end
    end

    nab_fifo #(
        .WIDTH (RW),
        .DEPTH (DEPTH)
    ) uFifo (
        .iCLK   (iCLK),
        .iRST   (iRST),
        .iValid (push),
        .oReady (fifoReady),
        .iData  (pushData),
        .oValid (bus.oValid_BM),
        .iReady (bus.iReady_BM),
        .oData  (bus.oData_BM)
    );
endmodule

// File: tb/tb_neuron_accumulator_bank.sv
// Directed bench for neuron_accumulator_bank (NA=4, NB=2, WD=4, NCH=2, DEPTH=2, OW=7).
module tb_neuron_accumulator_bank;
    import neuron_accumulator_bank_pkg::*;

    localparam int NA    = 4;
    localparam int NB    = 2;
    localparam int WD    = 4;
    localparam int NCH   = 2;
    localparam int DEPTH = 2;
    localparam int DW    = inWidth(NCH, NB, WD);
    localparam int RW    = outWidth(NCH, NB, NA, WD);
    localparam int DW2   = inWidth(3, NB, WD);
    localparam int RW2   = outWidth(3, NB, NA, WD);

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [NCH-1:0] err;
    logic [2:0]     err2;
    int             checks = 0;
    int             errors = 0;

    neuron_accumulator_bank_if #(.DW(DW),  .RW(RW))  bus  ();
    neuron_accumulator_bank_if #(.DW(DW2), .RW(RW2)) bus2 ();

    neuron_accumulator_bank #(.NA(NA), .NB(NB), .WD(WD), .NCH(NCH), .DEPTH(DEPTH)) dut (
        .iCLK (clk),
        .iRST (rst),
        .bus  (bus),
        .oErr (err)
    );

    // Three-channel instance so that an out-of-range channel number is encodable.
    neuron_accumulator_bank #(.NA(NA), .NB(NB), .WD(WD), .NCH(3), .DEPTH(DEPTH)) dut3 (
        .iCLK (clk),
        .iRST (rst),
        .bus  (bus2),
        .oErr (err2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [RW-1:0] pk(input int ch, input int s1, input int s0);
        logic [6:0] a;
        logic [6:0] b;
        a = 7'(s1);
        b = 7'(s0);
        return {ch[0], a, b};
    endfunction

    function automatic logic [DW-1:0] mk(input int ch, input int f, input int l,
                                         input int e, input int n, input int w0, input int w1);
        logic [3:0] a;
        logic [3:0] b;
        a = 4'(w1);
        b = 4'(w0);
        return {ch[0], f[0], l[0], e[0], n[0], a, b};
    endfunction

    task automatic beat(input int ch, input int f, input int l, input int e,
                        input int n, input int w0, input int w1);
        int waitN = 0;
        @(negedge clk);
        bus.iData_AS  = mk(ch, f, l, e, n, w0, w1);
        bus.iValid_AS = 1'b1;
        while (bus.oReady_AS !== 1'b1 && waitN < 50) begin
            @(negedge clk);
            waitN++;
        end
        chk("beat_accept", 32'(waitN < 50), 1);
        @(posedge clk);
        #1;
        bus.iValid_AS = 1'b0;
    endtask

    task automatic expectOut(input string tag, input logic [RW-1:0] exp);
        int waitN = 0;
        while (bus.oValid_BM !== 1'b1 && waitN < 20) begin
            @(negedge clk);
            waitN++;
        end
        chk({tag, "_valid"}, 32'(bus.oValid_BM), 1);
        chk(tag, 32'(bus.oData_BM), 32'(exp));
        bus.iReady_BM = 1'b1;
        @(posedge clk);
        #1;
        bus.iReady_BM = 1'b0;
    endtask

    initial begin
        bus.iValid_AS  = 1'b0;
        bus.iData_AS   = '0;
        bus.iReady_BM  = 1'b0;
        bus2.iValid_AS = 1'b0;
        bus2.iData_AS  = '0;
        bus2.iReady_BM = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(bus.oValid_BM), 0);
        chk("rst_ready", 32'(bus.oReady_AS), 1);
        chk("rst_err", 32'(err), 0);
        @(negedge clk);
        rst = 1'b1;

        // three-beat frame on ch0 -> (6,-1), one-edge latency
        beat(0, 1, 0, 1, 0, 3, -2);
        beat(0, 0, 0, 1, 0, 1, 1);
        chk("no_early_valid", 32'(bus.oValid_BM), 0);
        beat(0, 0, 1, 1, 0, 2, 0);
        chk("latency_valid", 32'(bus.oValid_BM), 1);
        expectOut("frame3", pk(0, -1, 6));
        chk("frame3_err", 32'(err), 0);

        // interleaved channels, negated -8 on last beat
        beat(1, 1, 0, 1, 0, 5, 5);
        beat(0, 1, 1, 1, 0, 1, 1);
        beat(1, 0, 1, 1, 1, -8, 1);
        expectOut("ilv_ch0", pk(0, 1, 1));
        expectOut("ilv_ch1", pk(1, 4, 13));

        // backpressure: two frames fill the FIFO, third beat stalls, drain in order
        beat(0, 1, 1, 1, 0, 1, 2);
        beat(1, 1, 1, 1, 0, 3, 4);
        chk("full_ready", 32'(bus.oReady_AS), 0);
        @(negedge clk);
        bus.iData_AS  = mk(0, 1, 1, 1, 0, 5, 6);
        bus.iValid_AS = 1'b1;
        chk("stall_ready", 32'(bus.oReady_AS), 0);
        @(negedge clk);
        chk("stall_hold", 32'(bus.oData_BM), 32'(pk(0, 2, 1)));
        bus.iReady_BM = 1'b1;
        @(posedge clk);
        #1;
        chk("drain_2nd", 32'(bus.oData_BM), 32'(pk(1, 4, 3)));
        chk("drain_ready", 32'(bus.oReady_AS), 1);
        @(posedge clk);
        #1;
        bus.iValid_AS = 1'b0;
        chk("pushpop_valid", 32'(bus.oValid_BM), 1);
        chk("drain_3rd", 32'(bus.oData_BM), 32'(pk(0, 6, 5)));
        @(posedge clk);
        #1;
        bus.iReady_BM = 1'b0;
        chk("drained", 32'(bus.oValid_BM), 0);

        // frame-length overrun on ch0
        for (int i = 0; i < 4; i++) beat(0, (i == 0) ? 1 : 0, 0, 1, 0, 7, 7);
        chk("err_before_overrun", 32'(err), 0);
        beat(0, 0, 0, 1, 0, 7, 7);
        chk("err_overrun", 32'(err), 1);
        beat(0, 0, 1, 0, 0, 7, 7);
        expectOut("overrun_sum", pk(0, 35, 35));

        // ten-beat frame on ch1 saturates both lanes
        for (int i = 0; i < 10; i++) beat(1, (i == 0) ? 1 : 0, (i == 9) ? 1 : 0, 1, 0, 7, -8);
        expectOut("saturate", pk(1, -64, 63));
        chk("err_both", 32'(err), 3);

        // en=0 frame
        beat(0, 1, 0, 0, 0, 7, 7);
        beat(0, 0, 1, 0, 1, 3, 3);
        expectOut("en_off", pk(0, 0, 0));

        // reset mid-frame with one FIFO entry pending
        beat(1, 1, 1, 1, 0, 2, 2);
        beat(0, 1, 0, 1, 0, 3, 3);
        chk("pre_rst_valid", 32'(bus.oValid_BM), 1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_async_valid", 32'(bus.oValid_BM), 0);
        chk("rst_async_err", 32'(err), 0);
        chk("rst_async_ready", 32'(bus.oReady_AS), 1);
        @(negedge clk);
        rst = 1'b1;
        beat(0, 0, 1, 1, 0, -1, 2);
        expectOut("post_rst", pk(0, 2, -1));

        // out-of-range channel on the three-channel instance
        @(negedge clk);
        bus2.iData_AS  = {2'd3, 1'b1, 1'b1, 1'b1, 1'b0, 4'd5, 4'd5};
        bus2.iValid_AS = 1'b1;
        chk("ch3_ready", 32'(bus2.oReady_AS), 1);
        @(posedge clk);
        #1;
        bus2.iValid_AS = 1'b0;
        repeat (2) @(negedge clk);
        chk("ch3_no_output", 32'(bus2.oValid_BM), 0);
        chk("ch3_no_err", 32'(err2), 0);
        bus2.iData_AS  = {2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 4'hD, 4'd1};
        bus2.iValid_AS = 1'b1;
        @(posedge clk);
        #1;
        bus2.iValid_AS = 1'b0;
        chk("ch2_valid", 32'(bus2.oValid_BM), 1);
        chk("ch2_data", 32'(bus2.oData_BM), 32'({2'd2, 7'h7D, 7'h01}));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
